// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_ctrl
//  Purpose  : Run-control sequencer for the single-cycle MIPS core. Owns the
//             core reset, qualifies PC advance and data-memory writes, and
//             provides run / pause / single-step, one address breakpoint, a
//             retired-instruction counter and an optional watchdog.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             start, step_mode      - launch (or return to idle), launch paused
//             pause_req, resume     - pause a run / leave pause for run
//             step_req              - execute one instruction from pause
//             bp_en, bp_addr        - address breakpoint
//             curr_inst_addr        - core's current PC
//             halt_in               - core's decoded halt for current inst
//             core_rst              - reset to the core datapath / PC
//             pc_en, dmem_we_en     - PC load enable / memW qualifier
//             state                 - IDLE=0 RUN=1 PAUSE=2 STEP=3 HALTED=4
//                                     TIMEOUT=5
//             brk, done, timeout    - status decodes
//             cyc_cnt               - retired-instruction count (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module mips_run_ctrl #(
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             pause_req,
    input  logic             resume,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [4:0]       bp_addr,
    input  logic [4:0]       curr_inst_addr,
    input  logic             halt_in,
    output logic             core_rst,
    output logic             pc_en,
    output logic             dmem_we_en,
    output logic [2:0]       state,
    output logic             brk,
    output logic             done,
    output logic             timeout,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_STEP    = 3'd3,
        ST_HALTED  = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    // Watchdog limit widened by one bit so the "count + 1" compare cannot wrap.
    localparam logic [CYC_W:0] c_max_cycles = (CYC_W+1)'(MAX_CYCLES);
    localparam bit             c_wd_enable  = (MAX_CYCLES != 0);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_brk;
    logic             w_brk_next;
    logic             r_bp_skip;
    logic [CYC_W-1:0] r_cyc_cnt;

    logic             w_bp_hit;
    logic             w_pc_en;
    logic             w_wd_hit;
    logic             w_cnt_sat;
    logic [CYC_W:0]   w_cnt_plus1;

    // ------------------------------------------------------------------------
    // Breakpoint and watchdog qualifiers
    // ------------------------------------------------------------------------
    // bp_skip suppresses the hit on the instruction we are resuming from, so
    // the paused instruction retires exactly once after leaving PAUSE.
    assign w_bp_hit    = bp_en & (curr_inst_addr == bp_addr) & ~r_bp_skip;
    assign w_cnt_sat   = &r_cyc_cnt;
    assign w_cnt_plus1 = {1'b0, r_cyc_cnt} + {{CYC_W{1'b0}}, 1'b1};
    // Fires when the retirement happening this edge brings the count to the
    // limit; only meaningful on a retiring edge.
    assign w_wd_hit    = c_wd_enable & w_pc_en & (w_cnt_plus1 == c_max_cycles);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_brk   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_brk   <= w_brk_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, enable and breakpoint-flag logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_brk_next   = 1'b0;
        w_pc_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = step_mode ? ST_PAUSE : ST_RUN;
                end
            end

            ST_RUN: begin
                w_pc_en = ~w_bp_hit & ~halt_in;
                // A breakpoint wins over halt: the instruction at the
                // breakpoint address has not executed yet.
                if (w_bp_hit) begin
                    w_state_next = ST_PAUSE;
                    w_brk_next   = 1'b1;
                end else if (halt_in) begin
                    w_state_next = ST_HALTED;
                end else if (w_wd_hit) begin
                    w_state_next = ST_TIMEOUT;
                end else if (pause_req) begin
                    w_state_next = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                w_brk_next = r_brk;
                if (step_req) begin
                    w_state_next = ST_STEP;
                    w_brk_next   = 1'b0;
                end else if (resume) begin
                    w_state_next = ST_RUN;
                    w_brk_next   = 1'b0;
                end
            end

            ST_STEP: begin
                // Single step ignores the breakpoint entirely.
                w_pc_en = ~halt_in;
                if (halt_in) begin
                    w_state_next = ST_HALTED;
                end else if (w_wd_hit) begin
                    w_state_next = ST_TIMEOUT;
                end else begin
                    w_state_next = ST_PAUSE;
                end
            end

            ST_HALTED, ST_TIMEOUT: begin
                if (start) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Breakpoint skip flag
    // ------------------------------------------------------------------------
    // Set when leaving PAUSE (pc_en is always low in PAUSE, so set and clear
    // never coincide); cleared by the first retirement afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bp_skip <= 1'b0;
        end else if (w_state_next == ST_IDLE) begin
            r_bp_skip <= 1'b0;
        end else if ((r_state == ST_PAUSE) && (w_state_next != ST_PAUSE)) begin
            r_bp_skip <= 1'b1;
        end else if (w_pc_en) begin
            r_bp_skip <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------------
    // Cleared on the edge that enters IDLE so the count already reads zero in
    // the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt <= '0;
        end else if (w_state_next == ST_IDLE) begin
            r_cyc_cnt <= '0;
        end else if (w_pc_en && !w_cnt_sat) begin
            r_cyc_cnt <= w_cnt_plus1[CYC_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc_en      = w_pc_en;
    assign dmem_we_en = w_pc_en;
    assign state      = r_state;
    assign core_rst   = (r_state == ST_IDLE);
    assign brk        = r_brk;
    assign done       = (r_state == ST_HALTED);
    assign timeout    = (r_state == ST_TIMEOUT);
    assign cyc_cnt    = r_cyc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_run_ctrl
//  Purpose  : Self-checking bench for mips_run_ctrl. A tiny PC model stands in
//             for the core: it resets on core_rst, advances on pc_en, and
//             takes per-address instruction kinds (normal / halt / branch-0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_run_ctrl;

    localparam int CYC_W = 16;

    logic             clk;
    logic             reset;
    logic             start, step_mode, pause_req, resume, step_req, bp_en;
    logic [4:0]       bp_addr;
    logic [4:0]       pc;
    logic             halt_in;
    logic             core_rst, pc_en, dmem_we_en, brk, done, timeout;
    logic [2:0]       state;
    logic [CYC_W-1:0] cyc_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Instruction kinds: 0 normal, 1 halt, 2 branch to address 0
    logic [1:0] prog [0:31];

    mips_run_ctrl #(.CYC_W(CYC_W), .MAX_CYCLES(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .step_mode      (step_mode),
        .pause_req      (pause_req),
        .resume         (resume),
        .step_req       (step_req),
        .bp_en          (bp_en),
        .bp_addr        (bp_addr),
        .curr_inst_addr (pc),
        .halt_in        (halt_in),
        .core_rst       (core_rst),
        .pc_en          (pc_en),
        .dmem_we_en     (dmem_we_en),
        .state          (state),
        .brk            (brk),
        .done           (done),
        .timeout        (timeout),
        .cyc_cnt        (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign halt_in = (prog[pc] == 2'd1);

    always @(posedge clk) begin
        if (reset || core_rst)  pc <= 5'd0;
        else if (pc_en)         pc <= (prog[pc] == 2'd2) ? 5'd0 : pc + 5'd1;
    end

    // Retirement monitor; mon_addr marks the address whose retirements
    // (memW-enabled edges) are tallied separately.
    logic       clr_mon;
    logic [4:0] mon_addr;
    int         n_ret, n_ret_addr;
    always @(negedge clk) begin
        if (clr_mon) begin
            n_ret      = 0;
            n_ret_addr = 0;
        end else if (pc_en) begin
            n_ret = n_ret + 1;
            if (dmem_we_en && pc == mon_addr) n_ret_addr = n_ret_addr + 1;
        end
    end

    typedef struct {
        logic       start;
        logic [2:0] e_state;
        logic       e_pc_en;
        logic [CYC_W-1:0] e_cnt;
        logic [4:0] e_pc;
    } vec_t;

    vec_t vecs [0:7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 2'd0;
    endtask

    task automatic clear_mon(input logic [4:0] addr);
        mon_addr = addr;
        clr_mon  = 1'b1;
        @(negedge clk);
        #1;
        clr_mon  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 0; step_mode = 0; pause_req = 0;
        resume = 0; step_req = 0; bp_en = 0; bp_addr = 5'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic sm);
        step_mode = sm;
        start     = 1'b1;
        #1;
        tick();
        start     = 1'b0;
        step_mode = 1'b0;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},    int'(state),      0);
        chk({tag, "_core_rst"}, int'(core_rst),   1);
        chk({tag, "_pc_en"},    int'(pc_en),      0);
        chk({tag, "_memw"},     int'(dmem_we_en), 0);
        chk({tag, "_brk"},      int'(brk),        0);
        chk({tag, "_done"},     int'(done),       0);
        chk({tag, "_timeout"},  int'(timeout),    0);
        chk({tag, "_cnt"},      int'(cyc_cnt),    0);
    endtask

    initial begin
        clr_mon = 1'b0; mon_addr = 5'd0;
        clear_prog();
        do_reset();
        chk_reset_vals("reset");

        // ---------------- add; add; halt (table driven) ----------------------
        prog[2] = 2'd1;
        vecs[0] = '{1'b1, 3'd0, 1'b0, 16'd0, 5'd0};
        vecs[1] = '{1'b0, 3'd1, 1'b1, 16'd0, 5'd0};
        vecs[2] = '{1'b0, 3'd1, 1'b1, 16'd1, 5'd1};
        vecs[3] = '{1'b0, 3'd1, 1'b0, 16'd2, 5'd2};
        vecs[4] = '{1'b0, 3'd4, 1'b0, 16'd2, 5'd2};
        vecs[5] = '{1'b1, 3'd4, 1'b0, 16'd2, 5'd2};
        vecs[6] = '{1'b0, 3'd0, 1'b0, 16'd0, 5'd2};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 16'd0, 5'd0};
        clear_mon(5'd2);
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start;
            #1;
            chk($sformatf("v%0d_state", i),   int'(state),   int'(vecs[i].e_state));
            chk($sformatf("v%0d_pc_en", i),   int'(pc_en),   int'(vecs[i].e_pc_en));
            chk($sformatf("v%0d_memw", i),    int'(dmem_we_en), int'(vecs[i].e_pc_en));
            chk($sformatf("v%0d_cnt", i),     int'(cyc_cnt), int'(vecs[i].e_cnt));
            chk($sformatf("v%0d_pc", i),      int'(pc),      int'(vecs[i].e_pc));
            chk($sformatf("v%0d_done", i),    int'(done),    (vecs[i].e_state == 3'd4) ? 1 : 0);
            chk($sformatf("v%0d_core_rst", i), int'(core_rst), (vecs[i].e_state == 3'd0) ? 1 : 0);
            if (i == 5) chk("halt_retired", n_ret, 2);
            tick();
        end
        start = 1'b0;

        // ---------------- breakpoint at address 3 ----------------------------
        do_reset();
        clear_prog();
        prog[4] = 2'd1;
        clear_mon(5'd3);
        bp_en = 1'b1; bp_addr = 5'd3;
        pulse_start(1'b0);
        for (int k = 0; k < 20 && state != 3'd2; k++) tick();
        chk("bp_state", int'(state),   2);
        chk("bp_brk",   int'(brk),     1);
        chk("bp_cnt",   int'(cyc_cnt), 3);
        chk("bp_pc",    int'(pc),      3);
        chk("bp_ret",   n_ret,         3);
        chk("bp_memw3", n_ret_addr,    0);
        resume = 1'b1;
        #1;
        chk("bp_pause_pc_en", int'(pc_en), 0);
        tick();
        resume = 1'b0;
        for (int k = 0; k < 20 && state != 3'd4; k++) tick();
        chk("bp_end_state", int'(state),   4);
        chk("bp_end_done",  int'(done),    1);
        chk("bp_end_brk",   int'(brk),     0);
        chk("bp_end_cnt",   int'(cyc_cnt), 4);
        chk("bp_ret3_once", n_ret_addr,    1);

        // ---------------- single step ---------------------------------------
        do_reset();
        clear_prog();
        prog[4] = 2'd1;
        clear_mon(5'd31);
        pulse_start(1'b1);
        chk("st_state", int'(state),   2);
        chk("st_cnt0",  int'(cyc_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            #1;
            tick();
            step_req = 1'b0;
            #1;
            chk($sformatf("st%0d_in_step", i), int'(state), 3);
            chk($sformatf("st%0d_pc_en", i),   int'(pc_en), 1);
            tick();
        end
        chk("st_pc3",    int'(pc),      3);
        chk("st_cnt3",   int'(cyc_cnt), 3);
        chk("st_ret3",   n_ret,         3);
        chk("st_paused", int'(state),   2);
        step_req = 1'b1; resume = 1'b1;
        #1;
        tick();
        step_req = 1'b0; resume = 1'b0;
        #1;
        chk("st_both_step", int'(state), 3);
        tick();
        tick();
        tick();
        chk("st_both_pause", int'(state),   2);
        chk("st_both_pc",    int'(pc),      4);
        chk("st_both_cnt",   int'(cyc_cnt), 4);
        chk("st_both_ret",   n_ret,         4);

        // ---------------- breakpoint and halt together -----------------------
        do_reset();
        clear_prog();
        prog[2] = 2'd1;
        clear_mon(5'd2);
        bp_en = 1'b1; bp_addr = 5'd2;
        pulse_start(1'b0);
        for (int k = 0; k < 20 && state != 3'd2; k++) tick();
        chk("bh_state", int'(state),   2);
        chk("bh_brk",   int'(brk),     1);
        chk("bh_cnt",   int'(cyc_cnt), 2);
        chk("bh_pc",    int'(pc),      2);
        step_req = 1'b1;
        #1;
        tick();
        step_req = 1'b0;
        #1;
        chk("bh_step",       int'(state), 3);
        chk("bh_step_pc_en", int'(pc_en), 0);
        tick();
        chk("bh_halted", int'(state),   4);
        chk("bh_done",   int'(done),    1);
        chk("bh_cnt2",   int'(cyc_cnt), 2);
        chk("bh_ret",    n_ret,         2);

        // ---------------- watchdog timeout ----------------------------------
        do_reset();
        clear_prog();
        prog[1] = 2'd2;
        clear_mon(5'd31);
        pulse_start(1'b0);
        for (int k = 0; k < 30 && state != 3'd5; k++) tick();
        chk("wd_state",   int'(state),   5);
        chk("wd_timeout", int'(timeout), 1);
        chk("wd_done",    int'(done),    0);
        chk("wd_cnt",     int'(cyc_cnt), 5);
        chk("wd_ret",     n_ret,         5);
        chk("wd_pc",      int'(pc),      1);
        tick();
        chk("wd_hold_cnt", int'(cyc_cnt), 5);
        pulse_start(1'b0);
        chk("wd_idle",     int'(state),   0);
        chk("wd_idle_cnt", int'(cyc_cnt), 0);

        // ---------------- reset mid-run, pause request, reset in pause -------
        do_reset();
        clear_prog();
        prog[1] = 2'd2;
        pulse_start(1'b0);
        tick();
        chk("rr_running", int'(state), 1);
        reset = 1'b1;
        #1;
        tick();
        chk_reset_vals("rr");
        reset = 1'b0;
        pulse_start(1'b0);
        tick();
        pause_req = 1'b1;
        #1;
        tick();
        pause_req = 1'b0;
        #1;
        chk("pr_state", int'(state),   2);
        chk("pr_brk",   int'(brk),     0);
        chk("pr_pc_en", int'(pc_en),   0);
        chk("pr_cnt",   int'(cyc_cnt), 2);
        reset = 1'b1;
        #1;
        tick();
        chk_reset_vals("rp");
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run-control sequencer for the single-cycle MIPS core. It owns core reset, gates PC advance and data-memory writes, and provides run, pause, single-step, one address breakpoint, a retired-instruction counter and a watchdog. It sits between the board/testbench control inputs and the `mips` core. It consumes the core's `halt` and `curr_inst_addr`, and produces the enables that qualify the PC register and `memW`.

## Interface
Parameters:
- `CYC_W`, 16: retired-instruction counter width.
- `MAX_CYCLES`, 0: watchdog limit in retired instructions. 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level sampled each cycle. Launches a run from IDLE, or returns to IDLE from HALTED/TIMEOUT.
- `step_mode`  in  1  when 1 at launch, enter PAUSE instead of RUN.
- `pause_req`  in  1  request to pause while running.
- `resume`  in  1  leave PAUSE for RUN.
- `step_req`  in  1  execute exactly one instruction from PAUSE.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  5  breakpoint instruction address.
- `curr_inst_addr`  in  5  core's current PC.
- `halt_in`  in  1  core's decoded halt for the current instruction.
- `core_rst`  out  1  reset to the core's datapath/PC.
- `pc_en`  out  1  PC may load `next_inst_addr` this edge.
- `dmem_we_en`  out  1  AND-gate for core `memW`; identical to `pc_en`.
- `state`  out  3  IDLE=0, RUN=1, PAUSE=2, STEP=3, HALTED=4, TIMEOUT=5.
- `brk`  out  1  PAUSE was entered by a breakpoint hit.
- `done`  out  1  state is HALTED.
- `timeout`  out  1  state is TIMEOUT.
- `cyc_cnt`  out  CYC_W  retired-instruction count.

## Operation
- `bp_hit` = `bp_en` & (`curr_inst_addr`==`bp_addr`) & ~`bp_skip`.
- `bp_skip` is an internal flag. It is set on any exit from PAUSE (to RUN or STEP). It clears after the first retired instruction.
- IDLE:
  - `core_rst`=1, `pc_en`=0, `cyc_cnt` held at 0.
  - `start` → PAUSE if `step_mode`, else RUN.
- RUN:
  - `pc_en` = ~`bp_hit` & ~`halt_in`.
  - Transition priority: `bp_hit` → PAUSE with `brk`=1 (the instruction is not executed). Else `halt_in` → HALTED (the halt instruction does not retire). Else watchdog (count reaches `MAX_CYCLES` on this retirement) → TIMEOUT. Else `pause_req` → PAUSE with `brk`=0. Else stay.
- PAUSE:
  - `pc_en`=0.
  - `step_req` → STEP. `step_req` has priority over `resume`; if both are high, only the step happens.
  - `resume` → RUN. `pause_req` is ignored in this state.
- STEP:
  - One cycle. `pc_en` = ~`halt_in`; the breakpoint is ignored.
  - `halt_in` → HALTED, else → PAUSE with `brk`=0.
  - The watchdog is also evaluated here and goes to TIMEOUT with the same rule as RUN.
- HALTED / TIMEOUT:
  - `pc_en`=0, `core_rst`=0; core state is preserved for inspection.
  - `start` → IDLE.
- Counter:
  - Increments on every edge with `pc_en`=1.
  - Saturates at all-ones.
  - Cleared in IDLE.

## Timing
- Reset values: state IDLE, `core_rst`=1, `pc_en`=0, `dmem_we_en`=0, `brk`=0, `done`=0, `timeout`=0, `cyc_cnt`=0, `bp_skip`=0.
- `reset` asserted in any state returns to IDLE on the next edge and overrides all other inputs.
- Latency:
  - `start` high at edge N puts the state in RUN after N. The first instruction retires at edge N+1 (the core leaves reset in that cycle).
- Outputs:
  - `pc_en` and `dmem_we_en` are combinational from state, `halt_in` and `bp_hit`.
  - `core_rst`, `brk`, `done`, `timeout` and `state` decode from registered state only.
- Control inputs are levels. A `step_req` held high for k cycles steps ⌈k/2⌉ times (STEP then PAUSE then STEP …).
- Breakpoint at the reset PC (0) with `bp_en`=1: the first RUN cycle pauses with `cyc_cnt`=0. `resume` then retires address 0 without re-hitting.

## Test plan
- Program `add;add;halt` at 0..2, `start`=1 one cycle → RUN. 2 retirements (`pc_en` high on exactly 2 edges). HALTED with `done`=1, `cyc_cnt`=2. PC stays at 2.
- `bp_en`=1, `bp_addr`=3 on a 6-instruction program → PAUSE with `brk`=1, `cyc_cnt`=3, PC=3, and no memW at address 3. `resume` → continues; address 3 retires once with no re-hit.
- `step_mode`=1, `start` → PAUSE. Three 1-cycle `step_req` pulses → PC 0→1→2→3, `cyc_cnt`=3, `pc_en` high exactly 3 cycles. `step_req`+`resume` together → one step only.
- `MAX_CYCLES`=5 with an infinite branch loop → TIMEOUT with `cyc_cnt`=5 and `timeout`=1. `start` → IDLE with `cyc_cnt`=0.
- In RUN, `bp_hit` and `halt_in` in the same cycle → PAUSE with `brk`=1 and no HALTED. Then `step_req` → HALTED with `cyc_cnt` unchanged.
- `reset` asserted mid-RUN and during PAUSE → next edge IDLE, all outputs at reset values, and no memW that cycle once state is IDLE.
